// File: rtl/sdrd_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sdrd_deserializer
// Purpose  : Samples SDRD once per key-PAL read window and assembles LSB-first
//            words for the host, with overrun flag and idle-timeout resync.
// Revision : 1.0
// ============================================================================
module sdrd_deserializer #(
   parameter int WORD_W     = 8,
   parameter int SAMPLE_DLY = 2,
   parameter int IDLE_TO    = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SSER,
   input  logic              BA13,
   input  logic              BA12,
   input  logic              BR_W,
   input  logic              SDRD,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ack,
   output logic              overrun,
   output logic [3:0]        bit_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [3:0]  c_dly       = 4'(SAMPLE_DLY);
   localparam logic [4:0]  c_word_w    = 5'(WORD_W);
   localparam logic [15:0] c_idle_last = 16'(IDLE_TO - 1);

   state_t             r_state;
   logic               r_win_d;
   logic [3:0]         r_dly_cnt;
   logic [15:0]        r_idle_cnt;
   // Only the WORD_W-1 most recent bits need storing; the newest bit comes
   // straight from SDRD when the word is assembled.
   logic [WORD_W-2:0]  r_sr;

   logic               w_win;
   logic               w_rise;
   logic               w_take;
   logic               w_done;
   logic               w_ack_ok;
   logic [4:0]         w_next_cnt;
   logic [WORD_W-1:0]  w_assembled;

   assign w_win       = ~SSER & ~BA13 & BA12 & BR_W;
   assign w_rise      = w_win & ~r_win_d;
   assign w_take      = (r_state == S_WAIT) && w_win && (r_dly_cnt == c_dly);
   assign w_next_cnt  = {1'b0, bit_cnt} + 5'd1;
   assign w_done      = w_take && (w_next_cnt == c_word_w);
   assign w_ack_ok    = word_ack & word_valid;
   assign w_assembled = {SDRD, r_sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_win_d    <= 1'b0;
         r_dly_cnt  <= 4'd0;
         r_idle_cnt <= 16'd0;
         r_sr       <= '0;
         bit_cnt    <= 4'd0;
         word_out   <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         r_win_d <= w_win;

         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state   <= S_WAIT;
                  r_dly_cnt <= 4'd1;
               end
            end
            S_WAIT: begin
               if (!w_win)
                  r_state <= S_IDLE;
               else if (r_dly_cnt == c_dly)
                  r_state <= S_SAMPLE;
               else
                  r_dly_cnt <= r_dly_cnt + 4'd1;
            end
            S_SAMPLE: r_state <= S_HOLD;
            S_HOLD: begin
               if (!w_win)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // The bit is captured on the edge that ends the last WAIT cycle.
         if (w_take) begin
            r_sr    <= w_assembled[WORD_W-1:1];
            bit_cnt <= w_done ? 4'd0 : w_next_cnt[3:0];
         end

         if (r_state == S_IDLE && !w_rise && bit_cnt != 4'd0) begin
            if (r_idle_cnt == c_idle_last) begin
               bit_cnt    <= 4'd0;
               r_sr       <= '0;
               r_idle_cnt <= 16'd0;
            end else begin
               r_idle_cnt <= r_idle_cnt + 16'd1;
            end
         end else begin
            r_idle_cnt <= 16'd0;
         end

         if (w_done && (!word_valid || word_ack)) begin
            word_out   <= w_assembled;
            word_valid <= 1'b1;
         end else if (w_ack_ok) begin
            word_valid <= 1'b0;
         end

         if (w_done && word_valid && !word_ack)
            overrun <= 1'b1;
         else if (w_ack_ok)
            overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdrd_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdrd_deserializer
// Purpose  : Directed stimulus with a word scoreboard for sdrd_deserializer.
// Revision : 1.0
// ============================================================================
module tb_sdrd_deserializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       SSER = 1'b1;
   logic       BA13 = 1'b0;
   logic       BA12 = 1'b1;
   logic       BR_W = 1'b1;
   logic       SDRD = 1'b1;
   logic       word_ack = 1'b0;
   logic [7:0] word_out;
   logic       word_valid;
   logic       overrun;
   logic [3:0] bit_cnt;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   bit         shown = 1'b0;

   sdrd_deserializer #(
      .WORD_W    (8),
      .SAMPLE_DLY(2),
      .IDLE_TO   (10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SSER      (SSER),
      .BA13      (BA13),
      .BA12      (BA12),
      .BR_W      (BR_W),
      .SDRD      (SDRD),
      .word_out  (word_out),
      .word_valid(word_valid),
      .word_ack  (word_ack),
      .overrun   (overrun),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // An accepted ack means the next valid word shown is a fresh one.
   always @(posedge clk)
      if (rst_n && word_ack && word_valid) shown = 1'b0;

   always @(negedge clk) begin
      if (!rst_n || !word_valid) begin
         shown = 1'b0;
      end else if (!shown) begin
         shown = 1'b1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got 0x%0h expected none", word_out);
         end else begin
            check("word_out", {24'd0, word_out}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic b, input int len, input int ack_cyc);
      for (int c = 0; c < len; c++) begin
         SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = b;
         word_ack = (c == ack_cyc);
         sync();
      end
      SSER = 1'b1; SDRD = 1'b1; word_ack = 1'b0;
      repeat (2) sync();
   endtask

   task automatic send_word(input logic [7:0] w, input int ack_last);
      for (int i = 0; i < 8; i++)
         access(w[i], 6, (i == 7) ? ack_last : -1);
   endtask

   task automatic ack_pulse();
      word_ack = 1'b1;
      sync();
      word_ack = 1'b0;
      sync();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] bits_a;
      repeat (3) sync();
      check("rst_word_out", {24'd0, word_out}, 32'h0);
      check("rst_valid", {31'd0, word_valid}, 32'h0);
      check("rst_overrun", {31'd0, overrun}, 32'h0);
      check("rst_bit_cnt", {28'd0, bit_cnt}, 32'h0);
      rst_n = 1'b1;
      repeat (2) sync();

      // Basic word: bits 1,0,1,1,0,0,1,0 LSB-first
      bits_a = 8'b0100_1101;
      exp_q.push_back(8'h4D);
      send_word(bits_a, -1);
      @(negedge clk);
      check("basic_valid", {31'd0, word_valid}, 32'h1);
      check("basic_out", {24'd0, word_out}, 32'h4D);
      check("basic_bit_cnt", {28'd0, bit_cnt}, 32'h0);
      sync();
      ack_pulse();
      @(negedge clk);
      check("ack_clears_valid", {31'd0, word_valid}, 32'h0);
      sync();

      // Short access aborts in WAIT
      access(1'b1, 2, -1);
      @(negedge clk);
      check("short_no_bit", {28'd0, bit_cnt}, 32'h0);
      sync();
      access(1'b1, 6, -1);
      @(negedge clk);
      check("after_short_bit_cnt", {28'd0, bit_cnt}, 32'h1);
      sync();

      // Idle timeout: three bits pending, then stay idle
      access(1'b0, 6, -1);
      access(1'b1, 6, -1);
      @(negedge clk);
      check("partial_bit_cnt", {28'd0, bit_cnt}, 32'h3);
      sync();
      repeat (4) sync();
      @(negedge clk);
      check("before_timeout", {28'd0, bit_cnt}, 32'h3);
      sync();
      repeat (8) sync();
      @(negedge clk);
      check("after_timeout", {28'd0, bit_cnt}, 32'h0);
      check("timeout_keeps_valid", {31'd0, word_valid}, 32'h0);
      sync();
      exp_q.push_back(8'hFF);
      send_word(8'hFF, -1);
      ack_pulse();

      // Overrun: second word dropped while first is unacknowledged
      exp_q.push_back(8'hA5);
      send_word(8'hA5, -1);
      send_word(8'h3C, -1);
      @(negedge clk);
      check("ovr_out_held", {24'd0, word_out}, 32'hA5);
      check("ovr_flag", {31'd0, overrun}, 32'h1);
      check("ovr_valid", {31'd0, word_valid}, 32'h1);
      sync();
      ack_pulse();
      @(negedge clk);
      check("ovr_ack_valid", {31'd0, word_valid}, 32'h0);
      check("ovr_ack_clear", {31'd0, overrun}, 32'h0);
      sync();

      // Completion and ack on the same edge
      exp_q.push_back(8'h11);
      send_word(8'h11, -1);
      exp_q.push_back(8'h22);
      send_word(8'h22, 2);
      @(negedge clk);
      check("simul_valid", {31'd0, word_valid}, 32'h1);
      check("simul_out", {24'd0, word_out}, 32'h22);
      check("simul_overrun", {31'd0, overrun}, 32'h0);
      sync();

      // Reset mid-word with an unacknowledged word present
      access(1'b1, 6, -1);
      access(1'b1, 6, -1);
      access(1'b0, 6, -1);
      access(1'b1, 6, -1);
      access(1'b0, 6, -1);
      @(negedge clk);
      check("pre_rst_bit_cnt", {28'd0, bit_cnt}, 32'h5);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_bit_cnt", {28'd0, bit_cnt}, 32'h0);
      check("async_rst_valid", {31'd0, word_valid}, 32'h0);
      check("async_rst_out", {24'd0, word_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) sync();
      exp_q.push_back(8'h96);
      send_word(8'h96, -1);
      @(negedge clk);
      check("post_rst_out", {24'd0, word_out}, 32'h96);
      sync();
      ack_pulse();

      repeat (3) sync();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
